// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: stall/flush/redirect control for the 5-stage core,
// data-memory wait watchdog and saturating performance counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_rd,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_branch,
  input  logic             ex_prediction,
  input  logic             ex_taken,
  input  logic [63:0]      ex_pc,
  input  logic [63:0]      ex_target,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_hold,
  output logic             redirect_valid,
  output logic [63:0]      redirect_pc,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_e;

  // 17 bits holds MEM_TIMEOUT-1 for the full legal range up to 2^16.
  localparam int                WCNT_W    = 17;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  flush_events_q, flush_events_d;

  logic load_use;
  logic mispredict;
  logic mem_wait;
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit    = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit    = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
  assign load_use   = ex_mem_rd && (ex_rd_addr != 5'd0) && (rs1_hit || rs2_hit);
  assign mispredict = ex_branch && (ex_taken != ex_prediction);
  assign mem_wait   = mem_req && !mem_ready;

  // Priority: watchdog error, memory wait, mispredict, load-use.
  always_comb begin
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    pipe_hold      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    if (rst) begin
      pc_stall = 1'b0;
    end else if (state_q == S_ERROR || mem_wait) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      pipe_hold   = 1'b1;
    end else if (mispredict) begin
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = ex_taken ? ex_target : (ex_pc + 64'd4);
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      S_RUN: begin
        if (mem_wait) begin
          state_d    = S_MEM_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      S_MEM_WAIT: begin
        // Leaving on mem_ready or on a dropped mem_req are both just !mem_wait.
        if (!mem_wait) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d       = S_ERROR;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      S_ERROR: begin
        state_d       = S_ERROR;
        mem_timeout_d = 1'b1;
      end
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (pc_stall && stall_cycles_q != CNT_MAX) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (redirect_valid && flush_events_q != CNT_MAX) begin
      flush_events_d = flush_events_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_RUN;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
  assign dbg_state    = state_q;

  a_rpc_zero: assert property (@(posedge clk) disable iff (rst)
    !redirect_valid |-> redirect_pc == 64'd0);
  a_no_stall_and_flush: assert property (@(posedge clk) disable iff (rst)
    !(if_id_stall && if_id_flush));
  a_hold_blocks_redirect: assert property (@(posedge clk) disable iff (rst)
    pipe_hold |-> (pc_stall && !redirect_valid && !id_ex_flush));

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It produces the stall and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the fetch redirect on branch mispredict. It detects load-use hazards, branch mispredicts and data-memory wait states, runs a memory-wait watchdog FSM, and keeps saturating performance counters.

Parameters:
MEM_TIMEOUT, 16, number of consecutive MEM_WAIT cycles (without mem_ready) after which the block enters ERROR; legal range is 2 to 2^16.
CNT_W, 32, width of the stall_cycles and flush_events counters.

Ports:
clk  in  1  core clock, rising edge
rst  in  1  reset; asynchronous, active-high
id_rs1_addr  in  5  rs1 of the instruction in ID
id_rs2_addr  in  5  rs2 of the instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_mem_rd  in  1  mem_rd of the instruction in EX (load)
ex_rd_addr  in  5  rd of the instruction in EX
ex_branch  in  1  EX holds a branch
ex_prediction  in  1  prediction carried with the EX branch (1 = taken)
ex_taken  in  1  resolved outcome of the EX branch
ex_pc  in  64  PC of the EX instruction
ex_target  in  64  resolved branch target
mem_req  in  1  MEM-stage instruction accesses data memory (mem_rd or mem_wr)
mem_ready  in  1  data memory completes the access this cycle
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  flush IF/ID to NOP
id_ex_flush  out  1  flush ID/EX to bubble
pipe_hold  out  1  hold EX/MEM and MEM/WB
redirect_valid  out  1  load redirect_pc into PC
redirect_pc  out  64  fetch redirect address
mem_timeout  out  1  sticky watchdog error
stall_cycles  out  CNT_W  cycles with pc_stall=1
flush_events  out  CNT_W  mispredicts serviced

Behaviour:
Reset:
- rst=1 asynchronously forces state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0, flush_events=0.
- While rst=1, all combinational outputs are 0.

Hazard terms (combinational, same cycle, zero latency):
- load_use = ex_mem_rd && ex_rd_addr!=0 && ((id_uses_rs1 && id_rs1_addr==ex_rd_addr) || (id_uses_rs2 && id_rs2_addr==ex_rd_addr)).
- mispredict = ex_branch && (ex_taken != ex_prediction).
- mem_wait = mem_req && !mem_ready.

Output priority per cycle, highest first:
1. state==ERROR:
   - pc_stall=if_id_stall=pipe_hold=1.
   - All flushes=0, redirect_valid=0, mem_timeout=1.
2. mem_wait:
   - pc_stall=if_id_stall=pipe_hold=1, id_ex_flush=0.
   - ID/EX holds by not being flushed while EX is frozen; the ID/EX register gains an enable driven from pipe_hold.
   - mispredict and load_use are ignored this cycle; they re-evaluate once the hold releases because EX/ID contents are unchanged.
3. mispredict:
   - if_id_flush=1, id_ex_flush=1, redirect_valid=1.
   - redirect_pc = ex_taken ? ex_target : ex_pc+4 (64-bit wrap).
   - Overrides a simultaneous load_use, because the ID instruction is wrong-path.
4. load_use:
   - pc_stall=1, if_id_stall=1, id_ex_flush=1.
   - Exactly one bubble; the next cycle the load is in MEM and forwarding covers it.
5. Otherwise: all outputs 0.

redirect_pc = 0 whenever redirect_valid=0.

FSM, registered:
- RUN:
  - mem_wait → MEM_WAIT with wait_cnt=1.
  - Otherwise stay, with wait_cnt=0.
- MEM_WAIT:
  - mem_ready=1 → RUN, wait_cnt=0.
  - mem_req drops to 0 → RUN (protocol violation tolerated).
  - mem_wait && wait_cnt==MEM_TIMEOUT-1 → ERROR.
  - Otherwise wait_cnt+1.
- ERROR: terminal until rst.
- A single-cycle wait (mem_ready the next cycle) costs exactly one hold cycle.

Counters:
- stall_cycles increments on every cycle with pc_stall=1, including ERROR.
- flush_events increments on every cycle where mispredict drives redirect_valid=1.
- Both saturate at 2^CNT_W-1 and never wrap.

Test Plan:
- Load-use: ex_mem_rd=1, ex_rd_addr=5, id_rs2_addr=5, id_uses_rs2=1 → pc_stall=if_id_stall=id_ex_flush=1 for 1 cycle, stall_cycles=1. The same stimulus with ex_rd_addr=0 → all outputs 0.
- Mispredict taken: ex_branch=1, ex_prediction=0, ex_taken=1, ex_target=0x1000 → redirect_valid=1, redirect_pc=0x1000, if_id_flush=id_ex_flush=1, flush_events=1. With ex_prediction=0, ex_taken=0 → no redirect.
- Not-taken correction: ex_prediction=1, ex_taken=0, ex_pc=0xFFFFFFFFFFFFFFFC → redirect_pc=0x0 (wrap).
- Simultaneous events: load_use and mispredict in the same cycle → only the mispredict outputs, pc_stall=0. mem_wait plus mispredict → pipe_hold=1, redirect_valid=0; when mem_ready=1 the next cycle, redirect fires.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → pipe_hold=1 for exactly 3 cycles, state returns to RUN, stall_cycles=3.
- Watchdog: MEM_TIMEOUT=4, mem_req=1, mem_ready held 0 → mem_timeout=1 from cycle 5 onward, sticky despite mem_ready=1. Asserting rst mid-ERROR → mem_timeout=0 and counters=0 immediately, without waiting for a clock edge.
